// File: rtl/card_board_pkg.sv
// board_pkg: shared geometry, widths and helpers for the card board.
//   N_CARDS/COLS/ROWS  grid geometry, card index = row*COLS + col
//   ADDR_W/RGB_W       card index and packed colour widths
//   R_W/G_W/B_W        colour field widths (RGB 3-3-2)
//   rgb_unpack()       split a packed colour into its fields
//   popcnt()           number of set bits in a per-card flag vector
package board_pkg;
    localparam int N_CARDS = 36;
    localparam int COLS    = 6;
    localparam int ROWS    = N_CARDS / COLS;
    localparam int ADDR_W  = 6;
    localparam int RGB_W   = 8;
    localparam int R_W     = 3;
    localparam int G_W     = 3;
    localparam int B_W     = 2;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    function automatic rgb_t rgb_unpack(input logic [RGB_W-1:0] v);
        rgb_t c;
        c.r = v[RGB_W-1 -: R_W];
        c.g = v[B_W +: G_W];
        c.b = v[B_W-1:0];
        return c;
    endfunction

    function automatic logic [ADDR_W-1:0] popcnt(input logic [N_CARDS-1:0] v);
        logic [ADDR_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CARDS; i++) c = c + ADDR_W'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/card_board_if.sv
// card_board_if: link between the pair matcher (master) and the board (slave).
//   addr        matcher colour read address
//   r/g/b       colour of card addr, combinational
//   ms/mf       matcher success / failure pulses
//   sel_bus     per-card selected flags
//   hidden_bus  per-card cleared flags
interface card_board_if;
    import board_pkg::*;
    logic [ADDR_W-1:0]  addr;
    logic [R_W-1:0]     r;
    logic [G_W-1:0]     g;
    logic [B_W-1:0]     b;
    logic               ms;
    logic               mf;
    logic [N_CARDS-1:0] sel_bus;
    logic [N_CARDS-1:0] hidden_bus;

    modport master (output addr, ms, mf, input r, g, b, sel_bus, hidden_bus);
    modport slave  (input addr, ms, mf, output r, g, b, sel_bus, hidden_bus);
endinterface

// File: rtl/card_board_cell.sv
// board_cell: state of one card -- colour, selected bit, hidden bit.
//   load_i/load_rgb_i  write colour, drops sel and hidden
//   pick_tgl_i         toggle the selected bit
//   clear_sel_i        drop selection (failed match)
//   hide_sel_i         move selection into hidden (successful match)
//   clear_all_i        new game: drop sel and hidden, keep colour
//   rgb_o/sel_o/hidden_o  current state
// Strobes are mutually exclusive by construction at the top; the order
// below only matters if that ever changes.
module board_cell
    import board_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [RGB_W-1:0] load_rgb_i,
    input  logic             pick_tgl_i,
    input  logic             clear_sel_i,
    input  logic             hide_sel_i,
    input  logic             clear_all_i,
    output logic [RGB_W-1:0] rgb_o,
    output logic             sel_o,
    output logic             hidden_o
);
    logic [RGB_W-1:0] rgb_q;
    logic             sel_q, hidden_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q    <= '0;
            sel_q    <= 1'b0;
            hidden_q <= 1'b0;
        end else if (clear_all_i) begin
            sel_q    <= 1'b0;
            hidden_q <= 1'b0;
        end else if (hide_sel_i) begin
            hidden_q <= hidden_q | sel_q;
            sel_q    <= 1'b0;
        end else if (clear_sel_i) begin
            sel_q    <= 1'b0;
        end else if (load_i) begin
            rgb_q    <= load_rgb_i;
            sel_q    <= 1'b0;
            hidden_q <= 1'b0;
        end else if (pick_tgl_i) begin
            sel_q    <= ~sel_q;
        end
    end

    assign rgb_o    = rgb_q;
    assign sel_o    = sel_q;
    assign hidden_o = hidden_q;
endmodule

// File: rtl/card_board.sv
// card_board: 6x6 card grid state and responder to the pair matcher.
//   clk, rst               clock, async active-high reset
//   load_we/addr/rgb       colour load from the deal logic
//   new_game               clear all flags and cleared_cnt
//   pick/pick_addr         player click from the cursor logic
//   mif (slave)            matcher link: colour read, ms/mf, sel/hidden buses
//   sel_cnt                selected cards (0..2)
//   cleared_cnt            cards cleared this game (0..36, saturating)
//   done                   all cards hidden
// One event per cycle wins: new_game > ms/mf > load_we > pick.
module card_board
    import board_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [RGB_W-1:0]  load_rgb,
    input  logic              new_game,
    input  logic              pick,
    input  logic [ADDR_W-1:0] pick_addr,
    card_board_if.slave       mif,
    output logic [1:0]        sel_cnt,
    output logic [ADDR_W-1:0] cleared_cnt,
    output logic              done
);
    logic [N_CARDS-1:0][RGB_W-1:0] col;
    logic [N_CARDS-1:0] sel, hid, load_hit, pick_hit, pick_tgl;
    logic match_go, hide_go, fail_go, load_slot, pick_slot, pick_ok;
    logic pick_on_sel, pick_on_hid;
    logic [1:0]        sel_cnt_q, sel_cnt_d;
    logic [ADDR_W-1:0] cleared_q, cleared_d;
    logic [ADDR_W:0]   cleared_sum;
    logic              done_q, done_d;
    logic [RGB_W-1:0]  rd;
    rgb_t              rd_f;

    // Arbitration. ms wins over mf when both pulse. A raised load_we
    // takes the slot even when its address is out of range.
    assign match_go  = mif.ms | mif.mf;
    assign hide_go   = !new_game && mif.ms;
    assign fail_go   = !new_game && !mif.ms && mif.mf;
    assign load_slot = !new_game && !match_go && load_we;
    assign pick_slot = !new_game && !match_go && !load_we && pick;

    // Address decode; out-of-range addresses match no card.
    always_comb begin
        load_hit = '0;
        pick_hit = '0;
        for (int i = 0; i < N_CARDS; i++) begin
            load_hit[i] = load_slot && (load_addr == ADDR_W'(i));
            pick_hit[i] = (pick_addr == ADDR_W'(i));
        end
    end

    assign pick_on_sel = |(pick_hit & sel);
    assign pick_on_hid = |(pick_hit & hid);
    // Deselect always allowed; a new select only while fewer than two held.
    assign pick_ok  = pick_slot && (|pick_hit) && !pick_on_hid
                      && (pick_on_sel || sel_cnt_q != 2'd2);
    assign pick_tgl = pick_ok ? pick_hit : '0;

    for (genvar i = 0; i < N_CARDS; i++) begin : g_cell
        board_cell u_cell (
            .clk         (clk),
            .rst         (rst),
            .load_i      (load_hit[i]),
            .load_rgb_i  (load_rgb),
            .pick_tgl_i  (pick_tgl[i]),
            .clear_sel_i (fail_go),
            .hide_sel_i  (hide_go),
            .clear_all_i (new_game),
            .rgb_o       (col[i]),
            .sel_o       (sel[i]),
            .hidden_o    (hid[i])
        );
    end

    assign cleared_sum = {1'b0, cleared_q} + {1'b0, popcnt(sel)};

    always_comb begin
        sel_cnt_d = sel_cnt_q;
        cleared_d = cleared_q;
        done_d    = done_q;
        if (new_game) begin
            sel_cnt_d = '0;
            cleared_d = '0;
            done_d    = 1'b0;
        end else if (match_go) begin
            sel_cnt_d = '0;
            if (mif.ms) begin
                cleared_d = (cleared_sum > (ADDR_W+1)'(N_CARDS)) ? ADDR_W'(N_CARDS)
                                                                 : cleared_sum[ADDR_W-1:0];
                done_d    = &(hid | sel);
            end
        end else if (|load_hit) begin
            if (|(load_hit & sel)) sel_cnt_d = sel_cnt_q - 2'd1;
            done_d = 1'b0;
        end else if (pick_ok) begin
            sel_cnt_d = pick_on_sel ? sel_cnt_q - 2'd1 : sel_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_cnt_q <= '0;
            cleared_q <= '0;
            done_q    <= 1'b0;
        end else begin
            sel_cnt_q <= sel_cnt_d;
            cleared_q <= cleared_d;
            done_q    <= done_d;
        end
    end

    // Zero-latency colour read; the matcher samples one edge after addr.
    always_comb begin
        rd = '0;
        for (int i = 0; i < N_CARDS; i++)
            if (mif.addr == ADDR_W'(i)) rd = col[i];
    end
    assign rd_f = rgb_unpack(rd);

    assign mif.r          = rd_f.r;
    assign mif.g          = rd_f.g;
    assign mif.b          = rd_f.b;
    assign mif.sel_bus    = sel;
    assign mif.hidden_bus = hid;
    assign sel_cnt        = sel_cnt_q;
    assign cleared_cnt    = cleared_q;
    assign done           = done_q;
endmodule

// File: tb/tb_card_board.sv
module tb_card_board;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_we = 0, new_game = 0, pick = 0;
    logic [5:0] load_addr = 0, pick_addr = 0;
    logic [7:0] load_rgb = 0;
    logic [1:0] sel_cnt;
    logic [5:0] cleared_cnt;
    logic       done;

    card_board_if mif ();

    card_board dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_rgb(load_rgb), .new_game(new_game), .pick(pick),
        .pick_addr(pick_addr), .mif(mif), .sel_cnt(sel_cnt),
        .cleared_cnt(cleared_cnt), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: plain per-card arrays and counters.
    logic [7:0] m_col [36];
    bit         m_sel [36];
    bit         m_hid [36];
    int         m_clr;
    bit         m_done;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Matcher protocol: ms only while a pair is held.
    always @(posedge clk)
        if (!rst && mif.ms)
            assert (sel_cnt == 2'd2) else $error("protocol: ms with sel_cnt=%0d", sel_cnt);

    function automatic logic [35:0] vec_sel();
        logic [35:0] v;
        for (int i = 0; i < 36; i++) v[i] = m_sel[i];
        return v;
    endfunction

    function automatic logic [35:0] vec_hid();
        logic [35:0] v;
        for (int i = 0; i < 36; i++) v[i] = m_hid[i];
        return v;
    endfunction

    function automatic int n_selected();
        int n = 0;
        for (int i = 0; i < 36; i++) n += int'(m_sel[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 36; i++) begin
            m_col[i] = 0; m_sel[i] = 0; m_hid[i] = 0;
        end
        m_clr = 0; m_done = 0;
    endtask

    task automatic model_step(input bit ng, ims, imf, lwe, input int la,
                              input logic [7:0] lrgb, input bit pk, input int pa);
        int  ns;
        bit  all;
        ns = n_selected();
        if (ng) begin
            for (int i = 0; i < 36; i++) begin m_sel[i] = 0; m_hid[i] = 0; end
            m_clr = 0; m_done = 0;
        end else if (ims || imf) begin
            if (ims) begin
                all = 1;
                for (int i = 0; i < 36; i++) begin
                    if (m_sel[i]) m_hid[i] = 1;
                    if (!m_hid[i]) all = 0;
                end
                m_clr = (m_clr + ns > 36) ? 36 : m_clr + ns;
                m_done = all;
            end
            for (int i = 0; i < 36; i++) m_sel[i] = 0;
        end else if (lwe) begin
            if (la < 36) begin
                m_col[la] = lrgb; m_sel[la] = 0; m_hid[la] = 0; m_done = 0;
            end
        end else if (pk) begin
            if (pa < 36 && !m_hid[pa]) begin
                if (m_sel[pa]) m_sel[pa] = 0;
                else if (ns < 2) m_sel[pa] = 1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".sel"},  mif.sel_bus,    vec_sel());
        chk({tag, ".hid"},  mif.hidden_bus, vec_hid());
        chk({tag, ".cnt"},  sel_cnt,        n_selected());
        chk({tag, ".clr"},  cleared_cnt,    m_clr);
        chk({tag, ".done"}, done,           m_done);
    endtask

    task automatic cyc(input string tag, input bit ng, ims, imf, lwe, input int la,
                       input logic [7:0] lrgb, input bit pk, input int pa);
        new_game = ng; mif.ms = ims; mif.mf = imf; load_we = lwe;
        load_addr = 6'(la); load_rgb = lrgb; pick = pk; pick_addr = 6'(pa);
        @(posedge clk);
        model_step(ng, ims, imf, lwe, la, lrgb, pk, pa);
        #1;
        new_game = 0; mif.ms = 0; mif.mf = 0; load_we = 0; pick = 0;
        check_state(tag);
    endtask

    task automatic do_pick(input int a);  cyc("pick", 0, 0, 0, 0, 0, 0, 1, a); endtask
    task automatic do_ms();               cyc("ms",   0, 1, 0, 0, 0, 0, 0, 0); endtask

    task automatic rd(input int a);
        logic [7:0] exp;
        mif.addr = 6'(a);
        #1;
        exp = (a < 36) ? m_col[a] : 8'd0;
        chk("rd", {mif.r, mif.g, mif.b}, exp);
    endtask

    initial begin
        int r, ns, la, pa;
        bit ims, imf, lwe, pk, ng;
        mif.addr = 0; mif.ms = 0; mif.mf = 0;
        model_reset();
        #12;
        check_state("reset");
        rd(35);
        @(negedge clk) rst = 0;

        // Deal colour i to card i.
        for (int i = 0; i < 36; i++) cyc("load", 0, 0, 0, 1, i, 8'(i), 0, 0);
        rd(35);
        chk("rd35", {mif.r, mif.g, mif.b}, 8'd35);
        rd(40);

        // Selection and lock.
        do_pick(0); do_pick(7);
        chk("lock.sel", mif.sel_bus, 36'h81);
        chk("lock.cnt", sel_cnt, 2'd2);
        do_pick(14);
        chk("lock.hold", mif.sel_bus, 36'h81);
        do_pick(7);
        chk("untog.sel", mif.sel_bus, 36'h1);
        chk("untog.cnt", sel_cnt, 2'd1);

        // Match 0 and 5.
        do_pick(5); do_ms();
        chk("ms.hid", mif.hidden_bus, 36'h21);
        chk("ms.clr", cleared_cnt, 6'd2);
        do_pick(5);
        chk("hidpick", mif.sel_bus, 36'h0);

        // Failed match 2 and 3.
        do_pick(2); do_pick(3);
        cyc("mf", 0, 0, 1, 0, 0, 0, 0, 0);
        chk("mf.hid", mif.hidden_bus, 36'h21);

        // Clear the remaining 17 pairs.
        begin
            int q[$];
            for (int i = 0; i < 36; i++) if (i != 0 && i != 5) q.push_back(i);
            while (q.size() >= 2) begin
                do_pick(q.pop_front()); do_pick(q.pop_front()); do_ms();
            end
        end
        chk("all.hid", mif.hidden_bus, {36{1'b1}});
        chk("all.clr", cleared_cnt, 6'd36);
        chk("all.done", done, 1'b1);
        cyc("ng", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("ng.done", done, 1'b0);
        rd(17);
        rd(35);

        // ms beats a same-cycle pick.
        do_pick(1); do_pick(4);
        cyc("ms+pick", 0, 1, 0, 0, 0, 0, 1, 9);
        chk("mp.hid", mif.hidden_bus, 36'h12);
        chk("mp.sel", mif.sel_bus, 36'h0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 99);
            ns = n_selected();
            ng = (r < 2);
            ims = 0; imf = 0;
            if (ns == 2 && r >= 2 && r < 45) begin
                ims = ($urandom_range(0, 3) != 0);
                imf = !ims || ($urandom_range(0, 3) == 0);
            end
            lwe = ($urandom_range(0, 11) == 0);
            la  = $urandom_range(0, 39);
            pk  = ($urandom_range(0, 3) != 0);
            pa  = $urandom_range(0, 39);
            if (lwe && la >= 36) pk = 0;
            cyc("rnd", ng, ims, imf, lwe, la, 8'($urandom), pk, pa);
            rd($urandom_range(0, 39));
        end

        // Async reset mid-cycle.
        do_pick(20);
        #2 rst = 1;
        model_reset();
        #1;
        check_state("arst");
        rd(35);
        @(negedge clk) rst = 0;
        do_pick(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
